// File: rtl/jt12_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jt12_pkg
// Description : Shared constants for the FM core timer path: the address of
//               the timer control register, the bit layout of that register,
//               and the default Timer A / Timer B / prescaler widths.
//               decode_timer_ctl() unpacks a 0x27 data byte for the register
//               stage.
// Revision    : 1.0 - initial release
// ============================================================================
package jt12_pkg;

    // Timer control / CSM mode register address
    localparam logic [7:0] REG_TIMER = 8'h27;

    // Bit positions inside register 0x27
    localparam int LOAD_A = 0;
    localparam int LOAD_B = 1;
    localparam int EN_A   = 2;
    localparam int EN_B   = 3;
    localparam int CLR_A  = 4;
    localparam int CLR_B  = 5;

    // Default counter widths
    localparam int TIMER_AW      = 10;
    localparam int TIMER_BW      = 8;
    localparam int TIMER_PRESC_W = 4;

    typedef struct packed {
        logic clr_b;
        logic clr_a;
        logic en_b;
        logic en_a;
        logic load_b;
        logic load_a;
    } timer_ctl_t;

    function automatic timer_ctl_t decode_timer_ctl(input logic [7:0] data);
        timer_ctl_t ctl;
        ctl.load_a = data[LOAD_A];
        ctl.load_b = data[LOAD_B];
        ctl.en_a   = data[EN_A];
        ctl.en_b   = data[EN_B];
        ctl.clr_a  = data[CLR_A];
        ctl.clr_b  = data[CLR_B];
        return ctl;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jt12_timer_cnt.sv
`default_nettype none
// ============================================================================
// Module      : jt12_timer_cnt
// Description : Up-counter with preset reload, used for both Timer A and
//               Timer B. Counts towards all-ones; the tick after all-ones is
//               an overflow, which reloads the preset.
// Ports       : clk, rst  - clock, synchronous active-high reset
//               tick      - count enable (already qualified by the caller)
//               start     - run bit just went 0->1: load preset, no count
//               run       - timer running
//               preset    - reload value
//               cnt       - current count
//               ovf       - combinational: this cycle's tick overflows
// Revision    : 1.0 - initial release
// ============================================================================
module jt12_timer_cnt #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         start,
    input  logic         run,
    input  logic [W-1:0] preset,
    output logic [W-1:0] cnt,
    output logic         ovf
);

    localparam logic [W-1:0] C_ONE = W'(1);

    logic [W-1:0] r_cnt;
    logic         w_at_max;
    logic         w_advance;

    assign w_at_max  = &r_cnt;
    // A start always wins over a coincident tick: the preset is loaded and
    // the tick is swallowed.
    assign w_advance = tick & run & ~start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (start) begin
            r_cnt <= preset;
        end else if (w_advance) begin
            // preset is sampled here, so a preset change while running only
            // takes effect at the next overflow
            r_cnt <= w_at_max ? preset : (r_cnt + C_ONE);
        end
    end

    assign cnt = r_cnt;
    assign ovf = w_advance & w_at_max;

endmodule
`default_nettype wire

// File: rtl/jt12_timer_unit.sv
`default_nettype none
// ============================================================================
// Module      : jt12_timer_unit
// Description : Timer A / Timer B block of the FM core. Holds the run bits,
//               the Timer B prescaler, the status flags and the IRQ line.
//               The Timer A overflow pulse goes back to the register stage
//               for CSM key-on. All counting advances on clk_en only.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               clk_en                 - sample-rate tick
//               timer_wr               - register 0x27 written this cycle
//               value_A / value_B      - timer presets
//               load_A / load_B        - run bits (valid with timer_wr)
//               enable_irq_A/B         - level, allow flag set
//               clr_flag_A/B           - flag clear (valid with timer_wr)
//               fast_timers            - bypass Timer B prescaler
//               flag_A / flag_B        - status flags
//               overflow_A             - one-cycle Timer A overflow pulse
//               irq_n                  - active-low interrupt
// Revision    : 1.0 - initial release
// ============================================================================
module jt12_timer_unit
    import jt12_pkg::*;
#(
    parameter int AW      = TIMER_AW,
    parameter int BW      = TIMER_BW,
    parameter int PRESC_W = TIMER_PRESC_W
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clk_en,
    input  logic          timer_wr,
    input  logic [AW-1:0] value_A,
    input  logic [BW-1:0] value_B,
    input  logic          load_A,
    input  logic          load_B,
    input  logic          enable_irq_A,
    input  logic          enable_irq_B,
    input  logic          clr_flag_A,
    input  logic          clr_flag_B,
    input  logic          fast_timers,
    output logic          flag_A,
    output logic          flag_B,
    output logic          overflow_A,
    output logic          irq_n
);

    localparam logic [PRESC_W-1:0] C_PRESC_ONE = PRESC_W'(1);

    logic               r_run_a;
    logic               r_run_b;
    logic [PRESC_W-1:0] r_presc;
    logic               r_flag_a;
    logic               r_flag_b;
    logic               r_overflow_a;
    logic               r_irq_n;

    logic               w_start_a;
    logic               w_start_b;
    logic               w_tick_b;
    logic               w_ovf_a;
    logic               w_ovf_b;
    logic [AW-1:0]      w_cnt_a;
    logic [BW-1:0]      w_cnt_b;
    logic               w_cnt_unused;

    // Reload only on a 0->1 run transition; rewriting 1 keeps counting.
    assign w_start_a = timer_wr & load_A & ~r_run_a;
    assign w_start_b = timer_wr & load_B & ~r_run_b;

    // Timer B advances once per prescaler wrap, or every tick in test mode.
    assign w_tick_b  = clk_en & ((&r_presc) | fast_timers);

    jt12_timer_cnt #(
        .W      (AW)
    ) u_timer_a (
        .clk    (clk),
        .rst    (rst),
        .tick   (clk_en),
        .start  (w_start_a),
        .run    (r_run_a),
        .preset (value_A),
        .cnt    (w_cnt_a),
        .ovf    (w_ovf_a)
    );

    jt12_timer_cnt #(
        .W      (BW)
    ) u_timer_b (
        .clk    (clk),
        .rst    (rst),
        .tick   (w_tick_b),
        .start  (w_start_b),
        .run    (r_run_b),
        .preset (value_B),
        .cnt    (w_cnt_b),
        .ovf    (w_ovf_b)
    );

    // Count values are kept as observation points only.
    assign w_cnt_unused = ^{w_cnt_a, w_cnt_b};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_a      <= 1'b0;
            r_run_b      <= 1'b0;
            r_presc      <= '0;
            r_flag_a     <= 1'b0;
            r_flag_b     <= 1'b0;
            r_overflow_a <= 1'b0;
            r_irq_n      <= 1'b1;
        end else begin
            if (timer_wr) begin
                r_run_a <= load_A;
                r_run_b <= load_B;
            end

            // Free-running, independent of run_B
            if (clk_en) begin
                r_presc <= r_presc + C_PRESC_ONE;
            end

            // Not gated by enable_irq_A: CSM key-on needs every overflow.
            r_overflow_a <= w_ovf_a;

            // Set has priority over a coincident clear.
            if (w_ovf_a && enable_irq_A) begin
                r_flag_a <= 1'b1;
            end else if (timer_wr && clr_flag_A) begin
                r_flag_a <= 1'b0;
            end

            if (w_ovf_b && enable_irq_B) begin
                r_flag_b <= 1'b1;
            end else if (timer_wr && clr_flag_B) begin
                r_flag_b <= 1'b0;
            end

            // Follows the registered flags, hence one cycle behind them.
            r_irq_n <= ~(r_flag_a | r_flag_b);
        end
    end

    assign flag_A     = r_flag_a;
    assign flag_B     = r_flag_b;
    assign overflow_A = r_overflow_a;
    assign irq_n      = r_irq_n;

endmodule
`default_nettype wire

// File: tb/tb_jt12_timer_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_jt12_timer_unit
// Description : Self-checking bench for jt12_timer_unit. Each vector drives
//               one clk cycle of inputs and queues the outputs expected after
//               that edge; the queue is popped and compared #1 after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_jt12_timer_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clk_en = 1'b0;
    logic       timer_wr = 1'b0;
    logic [9:0] value_A = '0;
    logic [7:0] value_B = '0;
    logic       load_A = 1'b0;
    logic       load_B = 1'b0;
    logic       enable_irq_A = 1'b0;
    logic       enable_irq_B = 1'b0;
    logic       clr_flag_A = 1'b0;
    logic       clr_flag_B = 1'b0;
    logic       fast_timers = 1'b0;
    logic       flag_A;
    logic       flag_B;
    logic       overflow_A;
    logic       irq_n;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic r, en, wr, la, lb, ca, cb;   // stimulus
        logic fa, fb, ov, irqn;            // expected after the edge
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl_a[31];

    jt12_timer_unit dut (
        .clk          (clk),
        .rst          (rst),
        .clk_en       (clk_en),
        .timer_wr     (timer_wr),
        .value_A      (value_A),
        .value_B      (value_B),
        .load_A       (load_A),
        .load_B       (load_B),
        .enable_irq_A (enable_irq_A),
        .enable_irq_B (enable_irq_B),
        .clr_flag_A   (clr_flag_A),
        .clr_flag_B   (clr_flag_B),
        .fast_timers  (fast_timers),
        .flag_A       (flag_A),
        .flag_B       (flag_B),
        .overflow_A   (overflow_A),
        .irq_n        (irq_n)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, en, wr, la, lb, ca, cb,
                                input logic fa, fb, ov, irqn);
        vec_t v;
        v.r = r;  v.en = en; v.wr = wr; v.la = la; v.lb = lb;
        v.ca = ca; v.cb = cb;
        v.fa = fa; v.fb = fb; v.ov = ov; v.irqn = irqn;
        return v;
    endfunction

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v, input string tag);
        vec_t e;
        rst        = v.r;
        clk_en     = v.en;
        timer_wr   = v.wr;
        load_A     = v.la;
        load_B     = v.lb;
        clr_flag_A = v.ca;
        clr_flag_B = v.cb;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".flag_A"},     flag_A,     e.fa);
            chk({tag, ".flag_B"},     flag_B,     e.fb);
            chk({tag, ".overflow_A"}, overflow_A, e.ov);
            chk({tag, ".irq_n"},      irq_n,      e.irqn);
        end
    endtask

    task automatic tick(input logic en, input logic fa, fb, ov, irqn,
                        input string tag);
        apply(mk(1'b0, en, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, fa, fb, ov, irqn), tag);
    endtask

    task automatic wr(input logic la, lb, ca, cb, en,
                      input logic fa, fb, ov, irqn, input string tag);
        apply(mk(1'b0, en, 1'b1, la, lb, ca, cb, fa, fb, ov, irqn), tag);
    endtask

    task automatic do_reset(input string tag);
        apply(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), tag);
    endtask

    initial begin
        // Timer A, value 1020, clk_en every 4 clk, clear in mid-period
        tbl_a[0]  = mk(0,0,1,1,0,0,0, 0,0,0,1);   // start, cnt=1020
        tbl_a[1]  = mk(0,1,0,0,0,0,0, 0,0,0,1);   // 1021
        tbl_a[2]  = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[3]  = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[4]  = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[5]  = mk(0,1,0,0,0,0,0, 0,0,0,1);   // 1022
        tbl_a[6]  = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[7]  = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[8]  = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[9]  = mk(0,1,0,0,0,0,0, 0,0,0,1);   // 1023
        tbl_a[10] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[11] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[12] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[13] = mk(0,1,0,0,0,0,0, 1,0,1,1);   // 4th tick: overflow
        tbl_a[14] = mk(0,0,0,0,0,0,0, 1,0,0,0);   // irq_n one later
        tbl_a[15] = mk(0,0,0,0,0,0,0, 1,0,0,0);
        tbl_a[16] = mk(0,0,0,0,0,0,0, 1,0,0,0);
        tbl_a[17] = mk(0,1,0,0,0,0,0, 1,0,0,0);   // 1021
        tbl_a[18] = mk(0,0,0,0,0,0,0, 1,0,0,0);
        tbl_a[19] = mk(0,0,1,1,0,1,0, 0,0,0,0);   // clear, load_A kept 1
        tbl_a[20] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[21] = mk(0,1,0,0,0,0,0, 0,0,0,1);   // 1022 (no restart)
        tbl_a[22] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[23] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[24] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[25] = mk(0,1,0,0,0,0,0, 0,0,0,1);   // 1023
        tbl_a[26] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[27] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[28] = mk(0,0,0,0,0,0,0, 0,0,0,1);
        tbl_a[29] = mk(0,1,0,0,0,0,0, 1,0,1,1);   // second overflow
        tbl_a[30] = mk(0,0,0,0,0,0,0, 1,0,0,0);

        // 1) Reset and idle ticking
        do_reset("rst0");
        do_reset("rst1");
        for (int i = 0; i < 50; i++)
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("idle[%0d]", i));

        // 2) Timer A table
        do_reset("rstA");
        value_A = 10'd1020;
        enable_irq_A = 1'b1;
        for (int i = 0; i < 31; i++)
            apply(tbl_a[i], $sformatf("tblA[%0d]", i));

        // 3) Timer B through prescaler: overflow on the 32nd clk_en
        do_reset("rstB");
        enable_irq_A = 1'b0;
        enable_irq_B = 1'b1;
        value_B = 8'd254;
        wr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "B.start");
        for (int i = 1; i <= 32; i++)
            tick(1'b1, 1'b0, (i == 32), 1'b0, 1'b1, $sformatf("Bslow[%0d]", i));
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "Bslow.irq");

        // 4) Timer B in fast mode: overflow on the 2nd clk_en
        do_reset("rstBf");
        fast_timers = 1'b1;
        wr(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "Bf.start");
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "Bfast[1]");
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "Bfast[2]");
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "Bfast.irq");
        fast_timers = 1'b0;
        enable_irq_B = 1'b0;

        // 5) Timer A period 2, IRQ disabled; stop, hold, restart
        do_reset("rstA2");
        value_A = 10'd1022;
        wr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "A2.start");
        for (int k = 1; k <= 9; k++)
            tick(1'b1, 1'b0, 1'b0, (k % 2 == 0), 1'b1, $sformatf("A2[%0d]", k));
        wr(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "A2.stop");
        for (int k = 0; k < 6; k++)
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("A2.held[%0d]", k));
        wr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "A2.restart");
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "A2.reload1");
        tick(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, "A2.reload2");

        // 6) Clear coinciding with overflow: set wins
        do_reset("rstSW");
        value_A = 10'd1023;
        enable_irq_A = 1'b1;
        wr(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "SW.start");
        tick(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "SW.ovf1");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "SW.irq");
        wr(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "SW.setwins");
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "SW.after");
        wr(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "SW.clear");
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "SW.irqoff");

        // 7) Reset mid-run with flag_B set and Timer A about to overflow
        do_reset("rstMR");
        value_A = 10'd1020;
        value_B = 8'd254;
        enable_irq_A = 1'b1;
        enable_irq_B = 1'b1;
        fast_timers = 1'b1;
        wr(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "MR.start");
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "MR[1]");
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "MR[2]");
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "MR[3]");
        apply(mk(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1), "MR.rst");
        for (int i = 0; i < 10; i++)
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, $sformatf("MR.post[%0d]", i));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
